// File: rtl/reg_rename_ctrl_pkg.sv
// Shared widths and types for the register rename controller.
// Register index, data width and register count live here so every file agrees.
package reg_rename_ctrl_pkg;

  localparam int REGNUM  = 32;
  localparam int REGIDXW = 5;
  localparam int DATALEN = 32;
  localparam int CNTW    = 6;

  typedef logic [REGIDXW-1:0] regindex_t;
  typedef logic [DATALEN-1:0] datalen_t;
  typedef logic [CNTW-1:0]    cnt_t;

  // Registered register-file write port.
  typedef struct packed {
    logic      we;
    regindex_t waddr;
    datalen_t  wdata;
  } rf_wr_t;

endpackage

// File: rtl/reg_rename_ctrl_if.sv
// Issue/commit/lookup/register-file bundle of the rename controller.
// The issue and ROB side drives through master; the controller sits on slave.
interface reg_rename_ctrl_if
  import reg_rename_ctrl_pkg::*;
#(
  parameter int ROB_TAG_W = 4
);

  logic                 rdy;
  logic                 jump_wrong;

  logic                 issue_valid;
  logic                 issue_has_rd;
  regindex_t            issue_rd;
  logic [ROB_TAG_W-1:0] issue_tag;
  regindex_t            issue_rs1;
  regindex_t            issue_rs2;

  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [ROB_TAG_W-1:0] rs1_tag;
  logic [ROB_TAG_W-1:0] rs2_tag;
  logic                 rs1_commit_hit;
  logic                 rs2_commit_hit;

  logic                 commit_valid;
  regindex_t            commit_rd;
  logic [ROB_TAG_W-1:0] commit_tag;
  datalen_t             commit_value;

  logic                 rf_we;
  regindex_t            rf_waddr;
  datalen_t             rf_wdata;
  cnt_t                 busy_cnt;

  modport master (
    output rdy, jump_wrong,
    output issue_valid, issue_has_rd, issue_rd, issue_tag, issue_rs1, issue_rs2,
    output commit_valid, commit_rd, commit_tag, commit_value,
    input  rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_commit_hit, rs2_commit_hit,
    input  rf_we, rf_waddr, rf_wdata, busy_cnt
  );

  modport slave (
    input  rdy, jump_wrong,
    input  issue_valid, issue_has_rd, issue_rd, issue_tag, issue_rs1, issue_rs2,
    input  commit_valid, commit_rd, commit_tag, commit_value,
    output rs1_busy, rs2_busy, rs1_tag, rs2_tag, rs1_commit_hit, rs2_commit_hit,
    output rf_we, rf_waddr, rf_wdata, busy_cnt
  );

endinterface

// File: rtl/reg_rename_ctrl.sv
// Per-register rename state (busy + producing ROB tag) with combinational
// source lookup, commit bypass hit, flush, and a registered register-file write.
module reg_rename_ctrl
  import reg_rename_ctrl_pkg::*;
#(
  parameter int ROB_TAG_W = 4
) (
  input logic               clk,
  input logic               rst,
  reg_rename_ctrl_if.slave  bus
);

  typedef logic [ROB_TAG_W-1:0] tag_t;

  logic [REGNUM-1:0] busy_q, busy_d;
  tag_t              tag_q [REGNUM];
  tag_t              tag_d [REGNUM];
  cnt_t              cnt_q, cnt_d;
  rf_wr_t            rf_q;

  logic issue_en;
  logic commit_en;
  logic commit_clr;

  assign issue_en  = bus.issue_valid && bus.issue_has_rd && (bus.issue_rd != '0);
  assign commit_en = bus.commit_valid && (bus.commit_rd != '0);

  // A commit only retires the rename if it is still the newest producer and
  // the same-cycle issue is not renaming that register again.
  assign commit_clr = commit_en && busy_q[bus.commit_rd]
                   && (tag_q[bus.commit_rd] == bus.commit_tag)
                   && !(issue_en && (bus.issue_rd == bus.commit_rd));

  // Source 1 lookup; x0 never has rename state.
  always_comb begin
    bus.rs1_busy       = 1'b0;
    bus.rs1_tag        = '0;
    bus.rs1_commit_hit = 1'b0;
    if (bus.issue_rs1 != '0) begin
      bus.rs1_tag = tag_q[bus.issue_rs1];
      if (busy_q[bus.issue_rs1]) begin
        if (bus.commit_valid && (bus.commit_rd == bus.issue_rs1)
            && (bus.commit_tag == tag_q[bus.issue_rs1]))
          bus.rs1_commit_hit = 1'b1;
        else
          bus.rs1_busy = 1'b1;
      end
    end
  end

  // Source 2 lookup, same rules as source 1.
  always_comb begin
    bus.rs2_busy       = 1'b0;
    bus.rs2_tag        = '0;
    bus.rs2_commit_hit = 1'b0;
    if (bus.issue_rs2 != '0) begin
      bus.rs2_tag = tag_q[bus.issue_rs2];
      if (busy_q[bus.issue_rs2]) begin
        if (bus.commit_valid && (bus.commit_rd == bus.issue_rs2)
            && (bus.commit_tag == tag_q[bus.issue_rs2]))
          bus.rs2_commit_hit = 1'b1;
        else
          bus.rs2_busy = 1'b1;
      end
    end
  end

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    cnt_d  = cnt_q;
    if (bus.jump_wrong) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (issue_en) begin
        busy_d[bus.issue_rd] = 1'b1;
        tag_d[bus.issue_rd]  = bus.issue_tag;
        if (!busy_q[bus.issue_rd])
          cnt_d = cnt_d + cnt_t'(1);
      end
      if (commit_clr) begin
        busy_d[bus.commit_rd] = 1'b0;
        cnt_d = cnt_d - cnt_t'(1);
      end
    end
  end

  // NOTE: the tag array is reset along with busy because tags are visible on
  // the lookup outputs even when not busy; state uses non-blocking updates only.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      tag_q  <= '{default: '0};
      cnt_q  <= '0;
      rf_q   <= '0;
    end else if (bus.rdy) begin
      busy_q      <= busy_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      rf_q.we     <= commit_en;
      rf_q.waddr  <= bus.commit_rd;
      rf_q.wdata  <= bus.commit_value;
    end else begin
      rf_q.we <= 1'b0;
    end
  end

  assign bus.rf_we    = rf_q.we;
  assign bus.rf_waddr = rf_q.waddr;
  assign bus.rf_wdata = rf_q.wdata;
  assign bus.busy_cnt = cnt_q;

endmodule

// File: tb/tb_reg_rename_ctrl.sv
// Bench for reg_rename_ctrl: directed scenarios followed by randomized traffic
// compared against an array-based model of the rename table.
module tb_reg_rename_ctrl;

  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_rename_ctrl_if #(.ROB_TAG_W(TW)) bus ();

  reg_rename_ctrl #(.ROB_TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural view of the rename table.
  bit          m_busy [32];
  int unsigned m_tag  [32];
  bit          m_we;
  int unsigned m_waddr;
  int unsigned m_wdata;

  function automatic int m_count();
    int n = 0;
    for (int i = 1; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit m_hit(int unsigned rs);
    return rs != 0 && m_busy[rs] && bus.commit_valid && bus.commit_rd == rs
           && bus.commit_tag == m_tag[rs];
  endfunction

  function automatic bit m_lbusy(int unsigned rs);
    return rs != 0 && m_busy[rs] && !m_hit(rs);
  endfunction

  function automatic int unsigned m_ltag(int unsigned rs);
    return (rs == 0) ? 0 : m_tag[rs];
  endfunction

  // Apply one clock edge to the model using the inputs held across it.
  task automatic model_edge();
    bit retire;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
      m_we = 0; m_waddr = 0; m_wdata = 0;
    end else if (bus.rdy) begin
      retire  = bus.commit_valid && bus.commit_rd != 0 && m_busy[bus.commit_rd]
                && m_tag[bus.commit_rd] == bus.commit_tag;
      m_we    = bus.commit_valid && bus.commit_rd != 0;
      m_waddr = bus.commit_rd;
      m_wdata = bus.commit_value;
      if (bus.jump_wrong) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
        if (retire) m_busy[bus.commit_rd] = 0;
        // Issue applied after the commit so a same-register rename wins.
        if (bus.issue_valid && bus.issue_has_rd && bus.issue_rd != 0) begin
          m_busy[bus.issue_rd] = 1;
          m_tag[bus.issue_rd]  = bus.issue_tag;
        end
      end
    end else begin
      m_we = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst              = 1'b0;
    bus.rdy          = 1'b1;
    bus.jump_wrong   = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.issue_has_rd = 1'b0;
    bus.issue_rd     = '0;
    bus.issue_tag    = '0;
    bus.issue_rs1    = '0;
    bus.issue_rs2    = '0;
    bus.commit_valid = 1'b0;
    bus.commit_rd    = '0;
    bus.commit_tag   = '0;
    bus.commit_value = '0;
  endtask

  task automatic issue(int unsigned rd, int unsigned tag);
    bus.issue_valid  = 1'b1;
    bus.issue_has_rd = 1'b1;
    bus.issue_rd     = 5'(rd);
    bus.issue_tag    = TW'(tag);
  endtask

  task automatic commit(int unsigned rd, int unsigned tag, int unsigned val);
    bus.commit_valid = 1'b1;
    bus.commit_rd    = 5'(rd);
    bus.commit_tag   = TW'(tag);
    bus.commit_value = val;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); tick();
    idle(); bus.issue_rs1 = 5'd5; bus.issue_rs2 = 5'd31; #1;
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %0b want 0", bus.rf_we); end
    total++; if (bus.rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata: got %0h want 0", bus.rf_wdata); end
    total++; if (bus.busy_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.busy_cnt); end
    total++; if (bus.rs1_busy !== 1'b0 || bus.rs1_tag !== 4'd0 || bus.rs2_busy !== 1'b0)
      begin bad++; $display("FAIL reset_lookup: got busy=%0b tag=%0d busy2=%0b want 0/0/0", bus.rs1_busy, bus.rs1_tag, bus.rs2_busy); end
  endtask

  task automatic test_issue_commit();
    idle(); issue(5, 3); bus.issue_rs1 = 5'd5; #1;
    total++; if (bus.rs1_busy !== 1'b0) begin bad++; $display("FAIL same_cycle_rename_visible: got %0b want 0", bus.rs1_busy); end
    tick();
    idle(); bus.issue_rs1 = 5'd5; #1;
    total++; if (bus.rs1_busy !== 1'b1 || bus.rs1_tag !== 4'd3)
      begin bad++; $display("FAIL rename_lookup: got busy=%0b tag=%0d want 1/3", bus.rs1_busy, bus.rs1_tag); end
    total++; if (bus.busy_cnt !== 6'd1) begin bad++; $display("FAIL rename_cnt: got %0d want 1", bus.busy_cnt); end
    commit(5, 3, 32'hDEAD); #1;
    total++; if (bus.rs1_commit_hit !== 1'b1 || bus.rs1_busy !== 1'b0)
      begin bad++; $display("FAIL commit_hit: got hit=%0b busy=%0b want 1/0", bus.rs1_commit_hit, bus.rs1_busy); end
    tick();
    idle(); bus.issue_rs1 = 5'd5; #1;
    total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEAD)
      begin bad++; $display("FAIL commit_write: got we=%0b a=%0d d=%0h want 1/5/dead", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    total++; if (bus.busy_cnt !== 6'd0 || bus.rs1_busy !== 1'b0 || bus.rs1_commit_hit !== 1'b0)
      begin bad++; $display("FAIL commit_clear: got cnt=%0d busy=%0b hit=%0b want 0/0/0", bus.busy_cnt, bus.rs1_busy, bus.rs1_commit_hit); end
  endtask

  task automatic test_stale_commit();
    idle(); issue(7, 2); tick();
    idle(); issue(7, 9); tick();
    idle(); commit(7, 2, 32'h1234_5678); bus.issue_rs1 = 5'd7; #1;
    total++; if (bus.rs1_commit_hit !== 1'b0 || bus.rs1_busy !== 1'b1 || bus.rs1_tag !== 4'd9)
      begin bad++; $display("FAIL stale_lookup: got hit=%0b busy=%0b tag=%0d want 0/1/9", bus.rs1_commit_hit, bus.rs1_busy, bus.rs1_tag); end
    tick();
    idle(); bus.issue_rs1 = 5'd7; #1;
    total++; if (bus.rs1_busy !== 1'b1 || bus.rs1_tag !== 4'd9 || bus.busy_cnt !== 6'd1)
      begin bad++; $display("FAIL stale_keep: got busy=%0b tag=%0d cnt=%0d want 1/9/1", bus.rs1_busy, bus.rs1_tag, bus.busy_cnt); end
    total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h1234_5678)
      begin bad++; $display("FAIL stale_write: got we=%0b a=%0d d=%0h want 1/7/12345678", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
  endtask

  task automatic test_issue_wins();
    idle(); issue(4, 1); tick();
    idle(); issue(4, 6); commit(4, 1, 32'hAAAA); tick();
    idle(); bus.issue_rs2 = 5'd4; #1;
    total++; if (bus.rs2_busy !== 1'b1 || bus.rs2_tag !== 4'd6 || bus.busy_cnt !== 6'd2)
      begin bad++; $display("FAIL issue_wins: got busy=%0b tag=%0d cnt=%0d want 1/6/2", bus.rs2_busy, bus.rs2_tag, bus.busy_cnt); end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin idle(); issue(r, r); tick(); end
    idle(); #1;
    total++; if (bus.busy_cnt !== 6'd5) begin bad++; $display("FAIL flush_pre_cnt: got %0d want 5", bus.busy_cnt); end
    bus.jump_wrong = 1'b1; issue(8, 5); commit(2, 2, 32'h55); tick();
    idle(); bus.issue_rs1 = 5'd8; bus.issue_rs2 = 5'd3; #1;
    total++; if (bus.busy_cnt !== 6'd0 || bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0)
      begin bad++; $display("FAIL flush_clear: got cnt=%0d b1=%0b b2=%0b want 0/0/0", bus.busy_cnt, bus.rs1_busy, bus.rs2_busy); end
    total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd2 || bus.rf_wdata !== 32'h55)
      begin bad++; $display("FAIL flush_write: got we=%0b a=%0d d=%0h want 1/2/55", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
  endtask

  task automatic test_x0_and_rdy();
    idle(); issue(0, 7); commit(0, 0, 32'hBEEF); bus.issue_rs1 = 5'd0; #1;
    total++; if (bus.rs1_busy !== 1'b0 || bus.rs1_tag !== 4'd0 || bus.rs1_commit_hit !== 1'b0)
      begin bad++; $display("FAIL x0_lookup: got busy=%0b tag=%0d hit=%0b want 0/0/0", bus.rs1_busy, bus.rs1_tag, bus.rs1_commit_hit); end
    tick();
    idle(); #1;
    total++; if (bus.rf_we !== 1'b0 || bus.busy_cnt !== 6'd0)
      begin bad++; $display("FAIL x0_write: got we=%0b cnt=%0d want 0/0", bus.rf_we, bus.busy_cnt); end
    commit(10, 0, 32'hCAFE); tick();
    idle(); bus.rdy = 1'b0; issue(9, 4); commit(11, 0, 32'h7777); tick();
    idle(); bus.issue_rs1 = 5'd9; #1;
    total++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd10 || bus.rf_wdata !== 32'hCAFE)
      begin bad++; $display("FAIL rdy_hold: got we=%0b a=%0d d=%0h want 0/10/cafe", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    total++; if (bus.rs1_busy !== 1'b0 || bus.busy_cnt !== 6'd0)
      begin bad++; $display("FAIL rdy_frozen: got busy=%0b cnt=%0d want 0/0", bus.rs1_busy, bus.busy_cnt); end
    issue(12, 1); tick();
    idle(); bus.rdy = 1'b0; rst = 1'b1; tick();
    idle(); bus.issue_rs1 = 5'd12; #1;
    total++; if (bus.rs1_busy !== 1'b0 || bus.busy_cnt !== 6'd0 || bus.rf_waddr !== 5'd0)
      begin bad++; $display("FAIL rst_over_rdy: got busy=%0b cnt=%0d a=%0d want 0/0/0", bus.rs1_busy, bus.busy_cnt, bus.rf_waddr); end
  endtask

  task automatic test_random(int cycles);
    int unsigned crd;
    for (int c = 0; c < cycles; c++) begin
      idle();
      rst              = ($urandom_range(99) == 0);
      bus.rdy          = ($urandom_range(9) != 0);
      bus.jump_wrong   = ($urandom_range(24) == 0);
      bus.issue_valid  = $urandom_range(1);
      bus.issue_has_rd = ($urandom_range(3) != 0);
      bus.issue_rd     = 5'($urandom_range(7));
      bus.issue_tag    = TW'($urandom_range(15));
      bus.issue_rs1    = 5'($urandom_range(7));
      bus.issue_rs2    = 5'($urandom_range(7));
      crd              = $urandom_range(7);
      bus.commit_valid = $urandom_range(1);
      bus.commit_rd    = 5'(crd);
      bus.commit_tag   = $urandom_range(1) ? TW'(m_tag[crd]) : TW'($urandom_range(15));
      bus.commit_value = $urandom;
      #1;
      total++;
      if (bus.rs1_busy !== m_lbusy(bus.issue_rs1) || bus.rs1_tag !== TW'(m_ltag(bus.issue_rs1))
          || bus.rs1_commit_hit !== m_hit(bus.issue_rs1)) begin
        bad++;
        $display("FAIL rand_rs1 c=%0d rs=%0d: got b=%0b t=%0d h=%0b want b=%0b t=%0d h=%0b", c, bus.issue_rs1,
                 bus.rs1_busy, bus.rs1_tag, bus.rs1_commit_hit, m_lbusy(bus.issue_rs1), m_ltag(bus.issue_rs1), m_hit(bus.issue_rs1));
      end
      total++;
      if (bus.rs2_busy !== m_lbusy(bus.issue_rs2) || bus.rs2_tag !== TW'(m_ltag(bus.issue_rs2))
          || bus.rs2_commit_hit !== m_hit(bus.issue_rs2)) begin
        bad++;
        $display("FAIL rand_rs2 c=%0d rs=%0d: got b=%0b t=%0d h=%0b want b=%0b t=%0d h=%0b", c, bus.issue_rs2,
                 bus.rs2_busy, bus.rs2_tag, bus.rs2_commit_hit, m_lbusy(bus.issue_rs2), m_ltag(bus.issue_rs2), m_hit(bus.issue_rs2));
      end
      tick();
      total++;
      if (bus.rf_we !== m_we || bus.rf_waddr !== 5'(m_waddr) || bus.rf_wdata !== m_wdata
          || bus.busy_cnt !== 6'(m_count())) begin
        bad++;
        $display("FAIL rand_regs c=%0d: got we=%0b a=%0d d=%0h cnt=%0d want we=%0b a=%0d d=%0h cnt=%0d", c,
                 bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.busy_cnt, m_we, m_waddr, m_wdata, m_count());
      end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_issue_commit();
    test_stale_commit();
    test_issue_wins();
    test_flush();
    test_x0_and_rdy();
    test_random(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
